munoc_master_req_packetizer: RTL and testbench

MUNOC_MASTER_REQ_PACKETIZER -- requirements
Module: munoc_master_req_packetizer

---
 rtl/munoc_master_req_packetizer_pkg.sv | 66 ++++++
 rtl/munoc_rr_arbiter2.sv | 39 +++
 rtl/munoc_master_req_packetizer.sv | 223 ++++++++++++++++++++++
 tb/tb_munoc_master_req_packetizer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/munoc_master_req_packetizer_pkg.sv
// Shared definitions for the MUNoC master request packetizer.
// Covers FSM encoding, request-type and grant encodings, header field layout and flit sizing.
package munoc_master_req_packetizer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RHEAD = 2'd1;
  localparam logic [1:0] ST_WHEAD = 2'd2;
  localparam logic [1:0] ST_WDATA = 2'd3;

  localparam logic IS_WRITE = 1'b1;
  localparam logic IS_READ  = 1'b0;

  localparam logic GRANT_AR = 1'b0;
  localparam logic GRANT_AW = 1'b1;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;

  // Header layout, LSB first: addr, burst, size, len, tid, dst, src, is_write
  function automatic int off_burst(input int bw_addr);
    return bw_addr;
  endfunction

  function automatic int off_size(input int bw_addr);
    return off_burst(bw_addr) + BURST_W;
  endfunction

  function automatic int off_len(input int bw_addr);
    return off_size(bw_addr) + SIZE_W;
  endfunction

  function automatic int off_tid(input int bw_addr);
    return off_len(bw_addr) + LEN_W;
  endfunction

  function automatic int off_dst(input int bw_addr, input int bw_tid);
    return off_tid(bw_addr) + bw_tid;
  endfunction

  function automatic int off_src(input int bw_addr, input int bw_tid, input int bw_node_id);
    return off_dst(bw_addr, bw_tid) + bw_node_id;
  endfunction

  function automatic int off_write(input int bw_addr, input int bw_tid, input int bw_node_id);
    return off_src(bw_addr, bw_tid, bw_node_id) + bw_node_id;
  endfunction

  function automatic int hdr_width(input int bw_addr, input int bw_tid, input int bw_node_id);
    return off_write(bw_addr, bw_tid, bw_node_id) + 1;
  endfunction

  function automatic int data_width(input int bw_data);
    return bw_data + bw_data / 8;
  endfunction

  function automatic int bw_flit(input int bw_addr, input int bw_data, input int bw_tid,
                                 input int bw_node_id);
    int h;
    int d;
    h = hdr_width(bw_addr, bw_tid, bw_node_id);
    d = data_width(bw_data);
    return (h > d) ? h : d;
  endfunction

endpackage

// File: rtl/munoc_rr_arbiter2.sv
// Two-way round-robin arbiter between the AW and AR channels.
// When both request, the channel that did not win last time is granted.
module munoc_rr_arbiter2
  import munoc_master_req_packetizer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_aw,
  input  logic req_ar,
  input  logic advance,
  output logic grant_aw,
  output logic grant_ar
);

  logic last_grant_r;

  // Grant selection from current requests and the last winner
  always_comb begin
    if (req_aw && req_ar) begin
      grant_aw = (last_grant_r == GRANT_AR);
      grant_ar = (last_grant_r == GRANT_AW);
    end else begin
      grant_aw = req_aw;
      grant_ar = req_ar;
    end
  end

  // Remember the winner of each taken grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= GRANT_AR;
    end else if (advance) begin
      last_grant_r <= grant_aw ? GRANT_AW : GRANT_AR;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/munoc_master_req_packetizer.sv
// Converts AXI AW/W/AR requests from one master into NoC request packets.
// Each packet is a header flit, followed for writes by awlen+1 data flits.
module munoc_master_req_packetizer
  import munoc_master_req_packetizer_pkg::*;
#(
  parameter int BW_ADDR        = 32,
  parameter int BW_DATA        = 32,
  parameter int BW_TID         = 4,
  parameter int BW_NODE_ID     = 4,
  parameter int MY_NODE_ID     = 0,
  parameter int ERROR_SLAVE_ID = 0,
  localparam int BW_FLIT       = bw_flit(BW_ADDR, BW_DATA, BW_TID, BW_NODE_ID)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BW_TID-1:0]       awid,
  input  logic [BW_ADDR-1:0]      awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [BW_DATA-1:0]      wdata,
  input  logic [BW_DATA/8-1:0]    wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [BW_TID-1:0]       arid,
  input  logic [BW_ADDR-1:0]      araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [BW_ADDR-1:0]      dec_addr,
  input  logic                    dec_hit,
  input  logic [BW_NODE_ID-1:0]   dec_node_id,
  output logic [BW_FLIT-1:0]      fwd_flit,
  output logic                    fwd_last,
  output logic                    fwd_valid,
  input  logic                    fwd_ready,
  output logic                    routing_error,
  output logic                    wlast_error
);

  localparam int DATA_W    = data_width(BW_DATA);
  localparam int OFF_BURST = off_burst(BW_ADDR);
  localparam int OFF_SIZE  = off_size(BW_ADDR);
  localparam int OFF_LEN   = off_len(BW_ADDR);
  localparam int OFF_TID   = off_tid(BW_ADDR);
  localparam int OFF_DST   = off_dst(BW_ADDR, BW_TID);
  localparam int OFF_SRC   = off_src(BW_ADDR, BW_TID, BW_NODE_ID);
  localparam int OFF_WRITE = off_write(BW_ADDR, BW_TID, BW_NODE_ID);

  logic [1:0]         state_r;
  logic [1:0]         state_next_s;
  logic [7:0]         cnt_r;
  logic [7:0]         cnt_next_s;
  logic [BW_FLIT-1:0] hdr_r;
  logic [BW_FLIT-1:0] hdr_next_s;
  logic [BW_FLIT-1:0] data_flit_s;
  logic               routing_error_r;
  logic               wlast_error_r;
  logic               grant_aw_s;
  logic               grant_ar_s;
  logic               idle_s;
  logic               take_s;
  logic               w_hs_s;
  logic               last_beat_s;

  // Only an idle, out-of-reset packetizer may accept a new request
  assign idle_s      = (state_r == ST_IDLE) && !rst;
  assign take_s      = idle_s && (grant_aw_s || grant_ar_s);
  assign awready     = take_s && grant_aw_s;
  assign arready     = take_s && grant_ar_s;
  assign last_beat_s = (cnt_r == 8'd0);
  assign w_hs_s      = (state_r == ST_WDATA) && wvalid && fwd_ready;

  assign routing_error = routing_error_r;
  assign wlast_error   = wlast_error_r;

  munoc_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_aw   (awvalid),
    .req_ar   (arvalid),
    .advance  (take_s),
    .grant_aw (grant_aw_s),
    .grant_ar (grant_ar_s)
  );

  // Address presented to the external decoder
  always_comb begin
    if (idle_s && grant_aw_s) begin
      dec_addr = awaddr;
    end else if (idle_s && grant_ar_s) begin
      dec_addr = araddr;
    end else begin
      dec_addr = {BW_ADDR{1'b0}};
    end
  end

  // Header flit assembled from the granted channel and decoder result
  always_comb begin
    hdr_next_s = {BW_FLIT{1'b0}};
    hdr_next_s[OFF_WRITE]              = grant_aw_s ? IS_WRITE : IS_READ;
    hdr_next_s[OFF_SRC +: BW_NODE_ID]  = BW_NODE_ID'(MY_NODE_ID);
    hdr_next_s[OFF_DST +: BW_NODE_ID]  = dec_hit ? dec_node_id : BW_NODE_ID'(ERROR_SLAVE_ID);
    hdr_next_s[OFF_TID +: BW_TID]      = grant_aw_s ? awid : arid;
    hdr_next_s[OFF_LEN +: LEN_W]       = grant_aw_s ? awlen : arlen;
    hdr_next_s[OFF_SIZE +: SIZE_W]     = grant_aw_s ? awsize : arsize;
    hdr_next_s[OFF_BURST +: BURST_W]   = grant_aw_s ? awburst : arburst;
    hdr_next_s[BW_ADDR-1:0]            = grant_aw_s ? awaddr : araddr;
  end

  // Data flit: write strobes above write data, zero-extended
  always_comb begin
    data_flit_s = {BW_FLIT{1'b0}};
    data_flit_s[DATA_W-1:0] = {wstrb, wdata};
  end

  // Packet framing: next state and beat counter
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_next_s = grant_aw_s ? ST_WHEAD : ST_RHEAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RHEAD: begin
        if (fwd_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RHEAD;
        end
      end
      ST_WHEAD: begin
        if (fwd_ready) begin
          state_next_s = ST_WDATA;
          cnt_next_s   = hdr_r[OFF_LEN +: LEN_W];
        end else begin
          state_next_s = ST_WHEAD;
        end
      end
      ST_WDATA: begin
        if (w_hs_s && last_beat_s) begin
          state_next_s = ST_IDLE;
        end else if (w_hs_s) begin
          cnt_next_s = cnt_r - 8'd1;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // State, counter, header and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      hdr_r           <= {BW_FLIT{1'b0}};
      routing_error_r <= 1'b0;
      wlast_error_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (take_s) begin
        hdr_r <= hdr_next_s;
      end else begin
        hdr_r <= hdr_r;
      end
      if (take_s && !dec_hit) begin
        routing_error_r <= 1'b1;
      end else begin
        routing_error_r <= routing_error_r;
      end
      // wlast only flags a framing disagreement; it never ends the burst
      if (w_hs_s && (wlast != last_beat_s)) begin
        wlast_error_r <= 1'b1;
      end else begin
        wlast_error_r <= wlast_error_r;
      end
    end
  end

  // Link outputs driven from the current state
  always_comb begin
    fwd_valid = 1'b0;
    fwd_last  = 1'b0;
    fwd_flit  = {BW_FLIT{1'b0}};
    wready    = 1'b0;
    case (state_r)
      ST_RHEAD: begin
        fwd_valid = 1'b1;
        fwd_last  = 1'b1;
        fwd_flit  = hdr_r;
      end
      ST_WHEAD: begin
        fwd_valid = 1'b1;
        fwd_flit  = hdr_r;
      end
      ST_WDATA: begin
        fwd_valid = wvalid;
        wready    = fwd_ready;
        fwd_flit  = data_flit_s;
        fwd_last  = last_beat_s;
      end
      default: begin
        fwd_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_munoc_master_req_packetizer.sv
// Randomized self-checking bench for munoc_master_req_packetizer.
// Expected flits come from a transaction-level model of the packet format.
module tb_munoc_master_req_packetizer;

  localparam int MY_NODE  = 2;
  localparam int ERR_NODE = 15;
  localparam int BW_FLIT  = 58;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         awid;
  logic [31:0]        awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awvalid;
  logic               awready;
  logic [31:0]        wdata;
  logic [3:0]         wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [3:0]         arid;
  logic [31:0]        araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arvalid;
  logic               arready;
  logic [31:0]        dec_addr;
  logic               dec_hit;
  logic [3:0]         dec_node_id;
  logic [BW_FLIT-1:0] fwd_flit;
  logic               fwd_last;
  logic               fwd_valid;
  logic               fwd_ready;
  logic               routing_error;
  logic               wlast_error;

  int n_checks = 0;
  int n_errors = 0;

  bit aw_pend;
  bit ar_pend;
  bit mdl_last_ar;
  bit mdl_routing_err;
  bit mdl_wlast_err;

  always #5 clk = ~clk;

  munoc_master_req_packetizer #(
    .BW_ADDR(32), .BW_DATA(32), .BW_TID(4), .BW_NODE_ID(4),
    .MY_NODE_ID(MY_NODE), .ERROR_SLAVE_ID(ERR_NODE)
  ) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .dec_addr(dec_addr), .dec_hit(dec_hit), .dec_node_id(dec_node_id),
    .fwd_flit(fwd_flit), .fwd_last(fwd_last), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .routing_error(routing_error), .wlast_error(wlast_error)
  );

  // Address map: top nibble F is unmapped, otherwise node = addr[15:12] ^ 4
  always_comb begin
    dec_hit     = (dec_addr[31:28] != 4'hF);
    dec_node_id = dec_addr[15:12] ^ 4'h4;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_hdr(input bit w, input logic [3:0] tid,
                                          input logic [31:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic [3:0] dst;
    dst = (addr[31:28] == 4'hF) ? 4'(ERR_NODE) : (addr[15:12] ^ 4'h4);
    return {6'd0, w, 4'(MY_NODE), dst, tid, len, size, burst, addr};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) == 0) a[31:28] = 4'hF;
    else if (a[31:28] == 4'hF) a[31:28] = 4'h0;
    return a;
  endfunction

  task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b);
    awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; aw_pend = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b);
    arid = id; araddr = a; arlen = l; arsize = s; arburst = b; ar_pend = 1'b1;
  endtask

  // One packet: grant, header, then write beats; abort_beat asserts rst at that beat
  task automatic run_one(input int bad_beat, input int abort_beat);
    bit          got;
    bit          is_w;
    logic [1:0]  exp_g;
    logic [63:0] hdr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] d;
    logic [3:0]  s;
    int          beats;

    exp_g = (aw_pend && ar_pend) ? (mdl_last_ar ? 2'b10 : 2'b01) : {aw_pend, ar_pend};
    got = 1'b0;
    is_w = 1'b0;
    hdr = 64'd0;
    len = 8'd0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      awvalid = aw_pend; arvalid = ar_pend; wvalid = 1'b0;
      fwd_ready = 1'($urandom_range(0, 1));
      #1;
      if (awready || arready) begin
        got = 1'b1;
        check_eq("grant", 64'({awready, arready}), 64'(exp_g));
        check_eq("idle_fwd_valid", 64'(fwd_valid), 64'd0);
        is_w = awready;
        addr = is_w ? awaddr : araddr;
        len  = is_w ? awlen : arlen;
        check_eq("dec_addr", 64'(dec_addr), 64'(addr));
        hdr = is_w ? exp_hdr(1'b1, awid, awaddr, awlen, awsize, awburst)
                   : exp_hdr(1'b0, arid, araddr, arlen, arsize, arburst);
        if (addr[31:28] == 4'hF) mdl_routing_err = 1'b1;
        mdl_last_ar = !is_w;
        if (is_w) aw_pend = 1'b0;
        else ar_pend = 1'b0;
      end
    end
    check_eq("grant_seen", 64'(got), 64'd1);
    if (!got) return;

    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      awvalid = aw_pend; arvalid = ar_pend;
      fwd_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("hdr_valid", 64'(fwd_valid), 64'd1);
      check_eq("hdr_flit", 64'(fwd_flit), hdr);
      check_eq("hdr_last", 64'(fwd_last), 64'(!is_w));
      check_eq("hdr_no_ready", 64'({awready, arready, wready}), 64'd0);
      got = fwd_ready;
    end

    beats = is_w ? int'(len) + 1 : 0;
    for (int b = 0; b < beats; b++) begin
      got = 1'b0;
      d = $urandom;
      s = 4'($urandom);
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (b == abort_beat) begin
          rst = 1'b1; awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1; fwd_ready = 1'b1;
          #1;
          check_eq("rst_handshakes", 64'({fwd_valid, fwd_last, awready, arready, wready}), 64'd0);
          check_eq("rst_flit", 64'(fwd_flit), 64'd0);
          check_eq("rst_dec_addr", 64'(dec_addr), 64'd0);
          aw_pend = 1'b0; ar_pend = 1'b0;
          mdl_last_ar = 1'b1; mdl_routing_err = 1'b0; mdl_wlast_err = 1'b0;
          return;
        end
        awvalid = aw_pend; arvalid = ar_pend;
        wvalid = 1'($urandom_range(0, 1));
        wdata = d; wstrb = s;
        wlast = (b == beats - 1) ^ (b == bad_beat);
        fwd_ready = 1'($urandom_range(0, 1));
        #1;
        check_eq("w_valid", 64'(fwd_valid), 64'(wvalid));
        check_eq("w_ready", 64'(wready), 64'(fwd_ready));
        check_eq("w_no_grant", 64'({awready, arready}), 64'd0);
        if (wvalid && fwd_ready) begin
          check_eq("w_flit", 64'(fwd_flit), 64'({s, d}));
          check_eq("w_last", 64'(fwd_last), 64'(b == beats - 1));
          if (b == bad_beat) mdl_wlast_err = 1'b1;
          got = 1'b1;
        end
      end
      check_eq("w_beat_seen", 64'(got), 64'd1);
    end

    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; fwd_ready = 1'b0;
    #1;
    check_eq("end_idle", 64'({fwd_valid, wready}), 64'd0);
    check_eq("routing_error", 64'(routing_error), 64'(mdl_routing_err));
    check_eq("wlast_error", 64'(wlast_error), 64'(mdl_wlast_err));
  endtask

  initial begin
    rst = 1'b1;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; fwd_ready = 1'b0;
    aw_pend = 1'b0; ar_pend = 1'b0;
    mdl_last_ar = 1'b1; mdl_routing_err = 1'b0; mdl_wlast_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs",
             64'({fwd_valid, fwd_last, awready, arready, wready, routing_error, wlast_error}), 64'd0);
    check_eq("reset_flit", 64'(fwd_flit), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Both channels kept requesting from reset: AW, AR, AW, AR
    for (int i = 0; i < 4; i++) begin
      if (!aw_pend) set_aw(4'($urandom), rand_addr(), 8'($urandom_range(0, 2)), 3'($urandom), 2'($urandom));
      if (!ar_pend) set_ar(4'($urandom), rand_addr(), 8'($urandom), 3'($urandom), 2'($urandom));
      check_eq("rr_order", 64'(mdl_last_ar), 64'((i % 2) == 0));
      run_one(-1, -1);
    end
    while (aw_pend || ar_pend) run_one(-1, -1);

    set_ar(4'd3, 32'h0000_1000, 8'd0, 3'd2, 2'd1);
    run_one(-1, -1);
    set_aw(4'd5, 32'h2000_0040, 8'd3, 3'd2, 2'd1);
    run_one(-1, -1);
    set_ar(4'd1, 32'hF000_0100, 8'd0, 3'd2, 2'd1);
    run_one(-1, -1);

    for (int i = 0; i < 40; i++) begin
      if (!aw_pend && $urandom_range(0, 1) == 1)
        set_aw(4'($urandom), rand_addr(), 8'($urandom_range(0, 4)), 3'($urandom), 2'($urandom));
      if (!ar_pend && ($urandom_range(0, 1) == 1 || !aw_pend))
        set_ar(4'($urandom), rand_addr(), 8'($urandom), 3'($urandom), 2'($urandom));
      run_one(-1, -1);
    end
    while (aw_pend || ar_pend) run_one(-1, -1);

    set_aw(4'd7, 32'h0000_3000, 8'd1, 3'd2, 2'd1);
    run_one(0, -1);

    // Reset lands during the second of four beats
    set_aw(4'd9, 32'h0000_6000, 8'd3, 3'd2, 2'd1);
    run_one(-1, 1);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_hold", 64'({fwd_valid, awready, arready, wready, routing_error, wlast_error}), 64'd0);
    @(negedge clk);
    rst = 1'b0; awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    set_ar(4'd2, 32'h0000_7000, 8'd0, 3'd1, 2'd1);
    run_one(-1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
